// File: rtl/mesh_term_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mesh_term_pkg
// Brief   : Shared types, packet field layout and helpers for mesh_term_agent.
// Rev     : 1.0  initial release
// ============================================================================
package mesh_term_pkg;

    // Field LSB positions, measured as distance below the packet width
    localparam int NXTJP_OFS = 8;
    localparam int ROW_OFS   = 12;
    localparam int COLUM_OFS = 16;
    localparam int MODE_OFS  = 17;
    localparam int HDR_W     = 17;
    localparam int PKT_MAX_W = 256;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_POP    = 2'd1,
        RX_SETTLE = 2'd2
    } rx_state_t;

    function automatic int mesh_term_drvs(input int rows, input int colums);
        return rows * 2 + colums * 2;
    endfunction

    // Result is PKT_MAX_W wide; callers cast it down to their own packet width.
    function automatic logic [PKT_MAX_W-1:0] pkt_build(
        input logic [7:0]           nxtjp,
        input logic [3:0]           row,
        input logic [3:0]           colum,
        input logic                 mode,
        input logic [PKT_MAX_W-1:0] payload,
        input int                   width
    );
        logic [PKT_MAX_W-1:0] pkt;
        pkt  = payload;
        pkt |= PKT_MAX_W'(nxtjp) << (width - NXTJP_OFS);
        pkt |= PKT_MAX_W'(row)   << (width - ROW_OFS);
        pkt |= PKT_MAX_W'(colum) << (width - COLUM_OFS);
        pkt |= PKT_MAX_W'(mode)  << (width - MODE_OFS);
        return pkt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_term_agent_fifo.sv
`default_nettype none
// ============================================================================
// Module  : term_fifo
// Brief   : Per-terminal inject FIFO with combinational head (DEPTH = 2^n).
// Rev     : 1.0  initial release
// ============================================================================
module term_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesh_term_agent.sv
`default_nettype none
// ============================================================================
// Module  : mesh_term_agent
// Brief   : Mesh edge agent: formats/buffers inject packets, drains deliveries.
//           Define MESH_TERM_STATS_EN for per-terminal inject/capture counters.
// Rev     : 1.0  initial release
// ============================================================================
module mesh_term_agent
    import mesh_term_pkg::*;
#(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = {8{1'b1}},
    localparam int        drvs       = mesh_term_drvs(ROWS, COLUMS),
    localparam int        TW         = $clog2(drvs),
    localparam int        CW         = $clog2(fifo_depth) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [TW-1:0]        in_term,
    input  logic [3:0]           in_row,
    input  logic [3:0]           in_colum,
    input  logic                 in_mode,
    input  logic                 in_bcast,
    input  logic [pckg_sz-18:0]  in_payload,
    output logic                 in_ready,
    output logic [drvs-1:0]      pndng_i_in,
    output logic [pckg_sz-1:0]   data_out_i_in [drvs],
    input  logic [drvs-1:0]      popin,
    input  logic [drvs-1:0]      pndng,
    input  logic [pckg_sz-1:0]   data_out [drvs],
    output logic [drvs-1:0]      pop,
    output logic [drvs-1:0]      rx_valid,
    output logic [pckg_sz-1:0]   rx_data [drvs],
    input  logic [drvs-1:0]      rx_ack
`ifdef MESH_TERM_STATS_EN
    ,
    output logic [15:0]          inj_cnt [drvs],
    output logic [15:0]          rx_cnt [drvs]
`endif
);

    logic [drvs-1:0]    w_push;
    logic [drvs-1:0]    w_empty;
    logic [drvs-1:0]    w_full;
    logic [CW-1:0]      w_count [drvs];
    logic [7:0]         w_nxtjp;
    logic [pckg_sz-1:0] w_pkt;
    logic               w_term_ok;
    logic               w_accept;

    assign w_nxtjp   = in_bcast ? bdcst : 8'h00;
    assign w_pkt     = pckg_sz'(pkt_build(w_nxtjp, in_row, in_colum, in_mode,
                                          PKT_MAX_W'(in_payload), pckg_sz));
    assign w_term_ok = (int'(in_term) < drvs);
    // A full FIFO refuses pushes even when popin frees a slot this cycle
    assign in_ready  = w_term_ok && !w_full[in_term];
    assign w_accept  = in_valid && in_ready;

    for (genvar t = 0; t < drvs; t++) begin : g_term
        rx_state_t          r_state;
        rx_state_t          w_state_nxt;
        logic               w_capture;
        logic               r_pop;
        logic               r_rx_valid;
        logic [pckg_sz-1:0] r_rx_data;

        assign w_push[t] = w_accept && (in_term == TW'(t));

        term_fifo #(
            .WIDTH (pckg_sz),
            .DEPTH (fifo_depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_push[t]),
            .pop   (popin[t]),
            .din   (w_pkt),
            .head  (data_out_i_in[t]),
            .empty (w_empty[t]),
            .full  (w_full[t]),
            .count (w_count[t])
        );

        assign pndng_i_in[t] = !w_empty[t];

        a_full_count: assert property (@(posedge clk) disable iff (!reset)
            w_full[t] == (w_count[t] == CW'(fifo_depth)));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) r_state <= RX_IDLE;
            else        r_state <= w_state_nxt;
        end

        // SETTLE gives the mesh a cycle to drop pndng after the pop pulse
        always_comb begin
            w_state_nxt = r_state;
            w_capture   = 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (pndng[t] && (!r_rx_valid || rx_ack[t])) begin
                        w_capture   = 1'b1;
                        w_state_nxt = RX_POP;
                    end
                end
                RX_POP:    w_state_nxt = RX_SETTLE;
                RX_SETTLE: w_state_nxt = RX_IDLE;
                default:   w_state_nxt = RX_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pop      <= 1'b0;
                r_rx_valid <= 1'b0;
                r_rx_data  <= '0;
            end else begin
                r_pop <= w_capture;
                if (w_capture) begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= data_out[t];
                end else if (rx_ack[t]) begin
                    r_rx_valid <= 1'b0;
                end
            end
        end

        assign pop[t]      = r_pop;
        assign rx_valid[t] = r_rx_valid;
        assign rx_data[t]  = r_rx_data;

`ifdef MESH_TERM_STATS_EN
        logic [15:0] r_inj_cnt;
        logic [15:0] r_rx_cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_inj_cnt <= '0;
                r_rx_cnt  <= '0;
            end else begin
                if (w_push[t] && (r_inj_cnt != 16'hFFFF)) r_inj_cnt <= r_inj_cnt + 16'd1;
                if (w_capture && (r_rx_cnt != 16'hFFFF))  r_rx_cnt  <= r_rx_cnt + 16'd1;
            end
        end

        assign inj_cnt[t] = r_inj_cnt;
        assign rx_cnt[t]  = r_rx_cnt;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_agent.sv
`default_nettype none
// ============================================================================
// Module  : tb_mesh_term_agent
// Brief   : Self-checking bench: vector table, directed corners, random + model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mesh_term_agent;

    localparam int N     = 16;
    localparam int PW    = 40;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [3:0]    in_term, in_row, in_colum;
    logic          in_mode, in_bcast;
    logic [22:0]   in_payload;
    logic          in_ready;
    logic [N-1:0]  pndng_i_in, popin, pndng, pop, rx_valid, rx_ack;
    logic [PW-1:0] data_out_i_in [N];
    logic [PW-1:0] data_out [N];
    logic [PW-1:0] rx_data [N];
`ifdef MESH_TERM_STATS_EN
    logic [15:0]   inj_cnt [N];
    logic [15:0]   rx_cnt [N];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mesh_term_agent dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_term       (in_term),
        .in_row        (in_row),
        .in_colum      (in_colum),
        .in_mode       (in_mode),
        .in_bcast      (in_bcast),
        .in_payload    (in_payload),
        .in_ready      (in_ready),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .pndng         (pndng),
        .data_out      (data_out),
        .pop           (pop),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ack        (rx_ack)
`ifdef MESH_TERM_STATS_EN
        ,
        .inj_cnt       (inj_cnt),
        .rx_cnt        (rx_cnt)
`endif
    );

    typedef struct {
        logic [3:0]    term, row, colum;
        logic          mode, bcast;
        logic [22:0]   payload;
        logic [PW-1:0] exp;
    } vec_t;

    // Reference model state
    logic [PW-1:0] q [N][$];
    bit            mv [N];
    logic [PW-1:0] md [N];
    int            cool [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_term = '0; in_row = '0; in_colum = '0;
        in_mode = 1'b0; in_bcast = 1'b0; in_payload = '0;
        popin = '0; pndng = '0; rx_ack = '0;
        for (int t = 0; t < N; t++) data_out[t] = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        for (int t = 0; t < N; t++) begin
            q[t].delete(); mv[t] = 0; md[t] = '0; cool[t] = 0;
        end
    endtask

    task automatic push(input logic [3:0] term, input logic [22:0] pl);
        in_valid = 1'b1; in_term = term; in_payload = pl;
        in_row = '0; in_colum = '0; in_mode = 1'b0; in_bcast = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_in(input int term);
        popin[term] = 1'b1;
        step();
        popin = '0;
    endtask

    // Packet as a sum of weighted fields
    function automatic logic [PW-1:0] pkt_ref(input logic bc, input logic [3:0] r,
                                              input logic [3:0] c, input logic m,
                                              input logic [22:0] p);
        longint unsigned v;
        v = (bc ? 64'd255 : 64'd0) * (64'd1 << 32) + 64'(r) * (64'd1 << 28)
          + 64'(c) * (64'd1 << 24) + 64'(m) * (64'd1 << 23) + 64'(p);
        return v[PW-1:0];
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t          vt [4];
        logic [N-1:0]  ep, ev, emp;
        logic          exp_ready;
        logic          cap;

        vt[0] = '{4'd0,  4'd0, 4'd2, 1'b1, 1'b0, 23'd1,        40'h0002800001};
        vt[1] = '{4'd0,  4'd0, 4'd2, 1'b1, 1'b1, 23'd1,        40'hFF02800001};
        vt[2] = '{4'd7,  4'd3, 4'd1, 1'b0, 1'b0, 23'h7FFFFF,   40'h00317FFFFF};
        vt[3] = '{4'd15, 4'hF, 4'hF, 1'b1, 1'b1, 23'd0,        40'hFFFF800000};

        // ---- reset state ----
        idle();
        reset = 1'b0;
        repeat (10) step();
        chk("rst_pndng_i_in", 64'(pndng_i_in), 64'd0);
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ---- asynchronous reset with traffic in flight ----
        push(4'd1, 23'd10);
        in_valid = 1'b1; in_term = 4'd1; in_payload = 23'd11;
        pndng[5] = 1'b1; data_out[5] = 40'h1234567890;
        step();
        in_valid = 1'b0; pndng = '0;
        chk("pre_arst_pop5", 64'(pop[5]), 64'd1);
        chk("pre_arst_pndng1", 64'(pndng_i_in[1]), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_pndng_i_in", 64'(pndng_i_in), 64'd0);
        chk("arst_pop", 64'(pop), 64'd0);
        chk("arst_rx_valid", 64'(rx_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        step(); step();
        reset = 1'b1;
        step();

        // ---- packet formatting table ----
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_term = vt[i].term; in_row = vt[i].row;
            in_colum = vt[i].colum; in_mode = vt[i].mode; in_bcast = vt[i].bcast;
            in_payload = vt[i].payload;
            #1;
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            step();
            idle();
            chk("vec_pndng_up", 64'(pndng_i_in[vt[i].term]), 64'd1);
            chk("vec_head", 64'(data_out_i_in[vt[i].term]), 64'(vt[i].exp));
            pop_in(int'(vt[i].term));
            chk("vec_pndng_down", 64'(pndng_i_in[vt[i].term]), 64'd0);
        end

        // ---- full FIFO, discard, order, pop on empty ----
        for (int k = 1; k <= 4; k++) push(4'd3, 23'(k));
        in_valid = 1'b1; in_term = 4'd3; in_payload = 23'd5;
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("full_order_pndng", 64'(pndng_i_in[3]), 64'd1);
            chk("full_order_head", 64'(data_out_i_in[3]), 64'(k));
            pop_in(3);
        end
        chk("drained_pndng", 64'(pndng_i_in[3]), 64'd0);
        pop_in(3);
        chk("empty_pop_pndng", 64'(pndng_i_in[3]), 64'd0);
        push(4'd3, 23'd6);
        chk("after_empty_pop_head", 64'(data_out_i_in[3]), 64'd6);
        pop_in(3);
        chk("after_empty_pop_drain", 64'(pndng_i_in[3]), 64'd0);

        // ---- simultaneous push and pop at count 2 ----
        push(4'd3, 23'h11);
        push(4'd3, 23'h22);
        in_valid = 1'b1; in_term = 4'd3; in_payload = 23'h33; popin[3] = 1'b1;
        step();
        idle();
        chk("pp_head", 64'(data_out_i_in[3]), 64'h22);
        pop_in(3);
        chk("pp_second_pndng", 64'(pndng_i_in[3]), 64'd1);
        chk("pp_second_head", 64'(data_out_i_in[3]), 64'h33);
        pop_in(3);
        chk("pp_count2_empty", 64'(pndng_i_in[3]), 64'd0);

        // ---- drain FSM ----
        pndng[5] = 1'b1; data_out[5] = 40'hAA00000055;
        step();
        chk("drain_pop", 64'(pop[5]), 64'd1);
        chk("drain_valid", 64'(rx_valid[5]), 64'd1);
        chk("drain_data", 64'(rx_data[5]), 64'hAA00000055);
        step();
        chk("drain_pop_pulse", 64'(pop[5]), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("drain_hold_nopop", 64'(pop), 64'd0);
        end
        chk("drain_hold_valid", 64'(rx_valid[5]), 64'd1);
        data_out[5] = 40'h0000000123; rx_ack[5] = 1'b1;
        step();
        rx_ack = '0;
        chk("ack_repop", 64'(pop[5]), 64'd1);
        chk("ack_replace_data", 64'(rx_data[5]), 64'h123);
        chk("ack_replace_valid", 64'(rx_valid[5]), 64'd1);
        pndng[5] = 1'b0;
        step(); step(); step();
        rx_ack[5] = 1'b1;
        step();
        rx_ack = '0;
        chk("ack_clear_valid", 64'(rx_valid[5]), 64'd0);
        rx_ack[5] = 1'b1;
        step();
        rx_ack = '0;
        chk("ack_idle_valid", 64'(rx_valid[5]), 64'd0);
        chk("ack_idle_pop", 64'(pop), 64'd0);

        // ---- randomized run against the model ----
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_term    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 1));
            in_row     = 4'($urandom);
            in_colum   = 4'($urandom);
            in_mode    = 1'($urandom);
            in_bcast   = 1'($urandom);
            in_payload = 23'($urandom);
            popin      = N'($urandom & $urandom);
            pndng      = N'($urandom);
            rx_ack     = N'($urandom & $urandom);
            for (int t = 0; t < N; t++) data_out[t] = {8'($urandom), 32'($urandom)};
            #1;
            exp_ready = (q[in_term].size() < DEPTH);
            chk("rand_in_ready", 64'(in_ready), 64'(exp_ready));
            for (int t = 0; t < N; t++)
                if (popin[t] && q[t].size() > 0) void'(q[t].pop_front());
            if (in_valid && exp_ready)
                q[in_term].push_back(pkt_ref(in_bcast, in_row, in_colum, in_mode, in_payload));
            for (int t = 0; t < N; t++) begin
                cap = pndng[t] && (cool[t] == 0) && (!mv[t] || rx_ack[t]);
                emp[t] = cap;
                if (cap) begin
                    mv[t] = 1; md[t] = data_out[t]; cool[t] = 2;
                end else begin
                    if (cool[t] > 0) cool[t]--;
                    if (rx_ack[t]) mv[t] = 0;
                end
            end
            step();
            for (int t = 0; t < N; t++) begin
                ep[t] = (q[t].size() > 0);
                ev[t] = mv[t];
            end
            chk("rand_pndng_i_in", 64'(pndng_i_in), 64'(ep));
            chk("rand_pop", 64'(pop), 64'(emp));
            chk("rand_rx_valid", 64'(rx_valid), 64'(ev));
            for (int t = 0; t < N; t++) begin
                if (q[t].size() > 0) chk("rand_head", 64'(data_out_i_in[t]), 64'(q[t][0]));
                if (mv[t]) chk("rand_rx_data", 64'(rx_data[t]), 64'(md[t]));
            end
        end

`ifdef MESH_TERM_STATS_EN
        // ---- statistics counters ----
        do_reset();
        for (int k = 0; k < 3; k++) push(4'd2, 23'(k));
        pndng[2] = 1'b1; rx_ack[2] = 1'b1; data_out[2] = 40'h55;
        repeat (4) step();
        pndng = '0; rx_ack = '0;
        step();
        chk("stats_inj3", 64'(inj_cnt[2]), 64'd3);
        chk("stats_rx2", 64'(rx_cnt[2]), 64'd2);
        in_valid = 1'b1; in_term = 4'd2; in_payload = 23'd9; popin[2] = 1'b1;
        repeat (65532) step();
        chk("stats_inj_ffff", 64'(inj_cnt[2]), 64'hFFFF);
        step();
        chk("stats_inj_sat", 64'(inj_cnt[2]), 64'hFFFF);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
